// File: rtl/sign_narrow_8to5.sv
// sign_narrow_8to5: streaming 8-bit to 5-bit signed narrower.
// Each accepted byte is range-checked against the 5-bit signed range
// (-16..+15). Out-of-range values are clamped or wrapped, depending on
// SATURATE. The result is buffered in an output register (O) backed by a
// skid register (S), so the block sustains one item per clock under a
// registered in_ready. Overflow statistics are gathered at input accept.
module sign_narrow_8to5 #(
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             in_fits;
  logic             in_ovf;
  logic [4:0]       in_conv;
  logic             accept;
  logic             o_free;

  logic             s_valid;
  logic [4:0]       s_data;
  logic             s_ovf;

  logic             o_valid_d;
  logic [4:0]       o_data_d;
  logic             o_ovf_d;
  logic             s_valid_d;
  logic [4:0]       s_data_d;
  logic             s_ovf_d;
  logic             in_ready_d;
  logic             sticky_d;
  logic [CNT_W-1:0] count_d;

  assign accept = in_valid & in_ready;
  // O can take a new item when it is empty or is being drained this cycle.
  assign o_free = ~out_valid | out_ready;

  // Range check and conversion of the incoming byte.
  always_comb begin
    in_fits = (in_data[7:4] == 4'b0000) || (in_data[7:4] == 4'b1111);
    in_ovf  = ~in_fits;
    in_conv = in_data[4:0];
    if (in_ovf && (SATURATE != 0)) begin
      in_conv = in_data[7] ? 5'b10000 : 5'b01111;
    end
  end

  // Next-state of the O/S buffer pair; S always drains into O before new data.
  always_comb begin
    o_valid_d = out_valid;
    o_data_d  = out_data;
    o_ovf_d   = out_ovf;
    s_valid_d = s_valid;
    s_data_d  = s_data;
    s_ovf_d   = s_ovf;

    if (o_free) begin
      if (s_valid) begin
        o_valid_d = 1'b1;
        o_data_d  = s_data;
        o_ovf_d   = s_ovf;
        if (accept) begin
          s_valid_d = 1'b1;
          s_data_d  = in_conv;
          s_ovf_d   = in_ovf;
        end else begin
          s_valid_d = 1'b0;
        end
      end else if (accept) begin
        o_valid_d = 1'b1;
        o_data_d  = in_conv;
        o_ovf_d   = in_ovf;
      end else begin
        o_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_conv;
      s_ovf_d   = in_ovf;
    end

    // Ready only while the skid slot will be free, so an accept never
    // finds both registers occupied.
    in_ready_d = ~s_valid_d;
  end

  // Overflow statistics; a clear coinciding with an overflow keeps that one.
  always_comb begin
    sticky_d = ovf_sticky;
    count_d  = ovf_count;
    if (clear) begin
      sticky_d = accept & in_ovf;
      count_d  = (accept & in_ovf) ? CNT_W'(1) : '0;
    end else if (accept && in_ovf) begin
      sticky_d = 1'b1;
      if (ovf_count != CNT_MAX) begin
        count_d = ovf_count + CNT_W'(1);
      end
    end
  end

  // State registers; reset empties both buffers and zeroes the statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_ovf      <= 1'b0;
      in_ready   <= 1'b1;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      out_valid  <= o_valid_d;
      out_data   <= o_data_d;
      out_ovf    <= o_ovf_d;
      s_valid    <= s_valid_d;
      s_data     <= s_data_d;
      s_ovf      <= s_ovf_d;
      in_ready   <= in_ready_d;
      ovf_sticky <= sticky_d;
      ovf_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_sign_narrow_8to5.sv
// Bench for sign_narrow_8to5: a saturating 8-bit-counter instance and a
// wrapping 2-bit-counter instance share one stimulus stream and are
// checked against a behavioural occupancy model plus expected-result queues.
module tb_sign_narrow_8to5;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_ovf, a_ovf_sticky;
  logic [4:0] a_out_data;
  logic [7:0] a_ovf_count;
  logic       b_in_ready, b_out_valid, b_out_ovf, b_ovf_sticky;
  logic [4:0] b_out_data;
  logic [1:0] b_ovf_count;

  sign_narrow_8to5 #(.SATURATE(1), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf),
    .ovf_sticky(a_ovf_sticky), .ovf_count(a_ovf_count)
  );

  sign_narrow_8to5 #(.SATURATE(0), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf),
    .ovf_sticky(b_ovf_sticky), .ovf_count(b_ovf_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int         occ;
  bit         rdy_m;
  bit         last_acc;
  logic [5:0] qa[$];
  logic [5:0] qb[$];
  bit         st_a, st_b;
  int         cnt_a, cnt_b;

  logic [7:0] fit_v[4]  = '{8'h0F, 8'hF3, 8'h00, 8'hF0};
  logic [7:0] sat_v[4]  = '{8'h10, 8'h7F, 8'hEF, 8'h80};
  logic [7:0] trn_v[2]  = '{8'h10, 8'hE0};
  logic [7:0] ovf5_v[5] = '{8'h20, 8'h55, 8'hC0, 8'h9A, 8'h7F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ovf, data} computed from the signed value, independent of bit slicing.
  function automatic logic [5:0] exp_conv(input logic [7:0] d, input bit sat);
    logic signed [7:0] sd;
    int v;
    logic o;
    logic [4:0] r;
    sd = d;
    v  = sd;
    o  = (v > 15) || (v < -16);
    r  = d[4:0];
    if (o && sat) r = (v < 0) ? 5'h10 : 5'h0F;
    return {o, r};
  endfunction

  task automatic model_reset();
    occ = 0;
    rdy_m = 1'b1;
    last_acc = 1'b0;
    qa.delete();
    qb.delete();
    st_a = 1'b0; st_b = 1'b0;
    cnt_a = 0;   cnt_b = 0;
  endtask

  // Check outputs at the negedge, advance the model, then step one clock.
  task automatic tick();
    logic [5:0] ea, eb, cv;
    bit xfer, acc, o;
    chk("a_out_valid", a_out_valid, occ > 0);
    chk("b_out_valid", b_out_valid, occ > 0);
    chk("a_in_ready", a_in_ready, rdy_m);
    chk("b_in_ready", b_in_ready, rdy_m);
    chk("a_sticky", a_ovf_sticky, st_a);
    chk("b_sticky", b_ovf_sticky, st_b);
    chk("a_count", a_ovf_count, cnt_a);
    chk("b_count", b_ovf_count, cnt_b);
    xfer = (occ > 0) && out_ready;
    acc  = in_valid && rdy_m;
    if (xfer) begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a_out_data", a_out_data, ea[4:0]);
      chk("a_out_ovf", a_out_ovf, ea[5]);
      chk("b_out_data", b_out_data, eb[4:0]);
      chk("b_out_ovf", b_out_ovf, eb[5]);
    end
    cv = exp_conv(in_data, 1'b1);
    o = acc && cv[5];
    if (acc) begin
      qa.push_back(cv);
      qb.push_back(exp_conv(in_data, 1'b0));
    end
    if (clear) begin
      st_a = o; st_b = o;
      cnt_a = o ? 1 : 0; cnt_b = o ? 1 : 0;
    end else if (o) begin
      st_a = 1'b1; st_b = 1'b1;
      if (cnt_a < 255) cnt_a++;
      if (cnt_b < 3) cnt_b++;
    end
    occ = occ - int'(xfer) + int'(acc);
    rdy_m = (occ <= 1);
    last_acc = acc;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_out_ovf", a_out_ovf, 0);
    chk("rst_a_sticky", a_ovf_sticky, 0);
    chk("rst_a_count", a_ovf_count, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_count", b_ovf_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Fitting values streamed back-to-back.
    out_ready = 1'b1;
    in_valid = 1'b1;
    foreach (fit_v[i]) begin in_data = fit_v[i]; tick(); end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("fit_a_count", a_ovf_count, 0);

    // Out-of-range values: A clamps, B wraps.
    in_valid = 1'b1;
    foreach (sat_v[i]) begin in_data = sat_v[i]; tick(); end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_a_count", a_ovf_count, 4);
    chk("sat_b_count", b_ovf_count, 3);
    chk("sat_a_sticky", a_ovf_sticky, 1);

    // Clear, then truncation pair.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_a_count", a_ovf_count, 0);
    chk("clr_b_sticky", b_ovf_sticky, 0);
    in_valid = 1'b1;
    foreach (trn_v[i]) begin in_data = trn_v[i]; tick(); end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("trn_b_count", b_ovf_count, 2);

    // Counter saturation in the 2-bit instance.
    in_valid = 1'b1;
    foreach (ovf5_v[i]) begin in_data = ovf5_v[i]; tick(); end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat5_b_count", b_ovf_count, 3);
    chk("sat5_a_count", a_ovf_count, 7);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr2_b_count", b_ovf_count, 0);
    chk("clr2_b_sticky", b_ovf_sticky, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h60; tick();
    clear = 1'b0; in_valid = 1'b0;
    tick();
    chk("clrovf_a_count", a_ovf_count, 1);
    chk("clrovf_b_count", b_ovf_count, 1);
    chk("clrovf_b_sticky", b_ovf_sticky, 1);
    repeat (2) tick();

    // Backpressure: third item must wait for the skid slot to free up.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_data = 8'h03; tick();
    tick();
    chk("bp_a_in_ready", a_in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    repeat (4) tick();

    // Asynchronous reset with both buffers full of overflow items.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h40; tick();
    in_data = 8'h90; tick();
    in_valid = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_a_out_valid", a_out_valid, 0);
    chk("arst_b_out_valid", b_out_valid, 0);
    chk("arst_a_count", a_ovf_count, 0);
    chk("arst_b_count", b_ovf_count, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b1; in_data = 8'h05; tick();
    in_valid = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
